shift_exec_stage: RTL and testbench

- Two-entry pipelined execute stage for the CPU's shift instructions: sll, srl, sra, sllv, srlv and srav.
- Decodes funct, shamt and register operands into shifter controls (operand, amount, arith, right), then drives the existing 32-bit combinational barrel shifter, instantiated internally.
- Registers the shifter result toward writeback with a valid/ready handshake.
- Sits between the ID/EX operand fetch and the EX/WB result path.

---
 rtl/shift_exec_stage.sv | 160 ++++++++++++++++
 tb/tb_shift_exec_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_exec_stage.sv
// Two-entry pipelined execute stage for sll/srl/sra/sllv/srlv/srav.
// Stage A holds decoded operands, stage B holds the registered shifter result.

module barrel_shifter_32 (
    input  logic [31:0] data_i,
    input  logic [4:0]  sa_i,
    input  logic        arith_i,
    input  logic        right_i,
    output logic [31:0] data_o
);
    // Kept as its own signed assignment so the arithmetic fill is not lost
    // to unsigned context in a mixed expression.
    logic signed [31:0] data_s;
    logic signed [31:0] sra_res;

    assign data_s  = data_i;
    assign sra_res = data_s >>> sa_i;

    always_comb begin
        data_o = data_i << sa_i;
        if (right_i) begin
            data_o = arith_i ? sra_res : (data_i >> sa_i);
        end
    end
endmodule

module shift_exec_stage (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        In_Valid,
    output logic        In_Ready,
    input  logic [5:0]  Funct,
    input  logic [4:0]  Shamt,
    input  logic [31:0] Rs,
    input  logic [31:0] Rt,
    input  logic        Flush,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic [31:0] Result,
    output logic        Out_Err
);
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;

    logic        valid_a_q, valid_a_d;
    logic [31:0] x_a_q, x_a_d;
    logic [4:0]  sa_a_q, sa_a_d;
    logic        right_a_q, right_a_d;
    logic        arith_a_q, arith_a_d;
    logic        err_a_q, err_a_d;
    logic        valid_b_q, valid_b_d;
    logic [31:0] result_b_q, result_b_d;
    logic        err_b_q, err_b_d;

    logic [4:0]  dec_sa;
    logic        dec_right;
    logic        dec_arith;
    logic        dec_err;
    logic [31:0] shift_y;
    logic        adv_b;
    logic        accept;
    logic        unused_rs_hi;

    // Variable shifts take only the low five bits of rs.
    assign unused_rs_hi = ^Rs[31:5];

    always_comb begin
        dec_sa    = 5'd0;
        dec_right = 1'b0;
        dec_arith = 1'b0;
        dec_err   = 1'b0;
        unique case (Funct)
            FN_SLL:  dec_sa = Shamt;
            FN_SRL:  begin dec_sa = Shamt;   dec_right = 1'b1; end
            FN_SRA:  begin dec_sa = Shamt;   dec_right = 1'b1; dec_arith = 1'b1; end
            FN_SLLV: dec_sa = Rs[4:0];
            FN_SRLV: begin dec_sa = Rs[4:0]; dec_right = 1'b1; end
            FN_SRAV: begin dec_sa = Rs[4:0]; dec_right = 1'b1; dec_arith = 1'b1; end
            default: dec_err = 1'b1;
        endcase
    end

    barrel_shifter_32 u_shifter (
        .data_i  (x_a_q),
        .sa_i    (sa_a_q),
        .arith_i (arith_a_q),
        .right_i (right_a_q),
        .data_o  (shift_y)
    );

    assign adv_b    = ~valid_b_q | Out_Ready;
    assign In_Ready = ~valid_a_q | adv_b;
    assign accept   = In_Valid & In_Ready & ~Flush;

    always_comb begin
        valid_a_d  = valid_a_q;
        x_a_d      = x_a_q;
        sa_a_d     = sa_a_q;
        right_a_d  = right_a_q;
        arith_a_d  = arith_a_q;
        err_a_d    = err_a_q;
        valid_b_d  = valid_b_q;
        result_b_d = result_b_q;
        err_b_d    = err_b_q;
        if (Flush) begin
            valid_a_d = 1'b0;
            valid_b_d = 1'b0;
        end else begin
            if (adv_b) begin
                valid_b_d = valid_a_q;
                if (valid_a_q) begin
                    result_b_d = err_a_q ? 32'd0 : shift_y;
                    err_b_d    = err_a_q;
                end
            end
            if (accept) begin
                valid_a_d = 1'b1;
                x_a_d     = Rt;
                sa_a_d    = dec_sa;
                right_a_d = dec_right;
                arith_a_d = dec_arith;
                err_a_d   = dec_err;
            end else if (adv_b) begin
                valid_a_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            valid_a_q  <= 1'b0;
            x_a_q      <= 32'd0;
            sa_a_q     <= 5'd0;
            right_a_q  <= 1'b0;
            arith_a_q  <= 1'b0;
            err_a_q    <= 1'b0;
            valid_b_q  <= 1'b0;
            result_b_q <= 32'd0;
            err_b_q    <= 1'b0;
        end else begin
            valid_a_q  <= valid_a_d;
            x_a_q      <= x_a_d;
            sa_a_q     <= sa_a_d;
            right_a_q  <= right_a_d;
            arith_a_q  <= arith_a_d;
            err_a_q    <= err_a_d;
            valid_b_q  <= valid_b_d;
            result_b_q <= result_b_d;
            err_b_q    <= err_b_d;
        end
    end

    assign Out_Valid = valid_b_q;
    assign Result    = result_b_q;
    assign Out_Err   = err_b_q;
endmodule

// File: tb/tb_shift_exec_stage.sv
// Scoreboard bench for shift_exec_stage: issue pushes expected results,
// a negedge monitor pops and compares on every output handshake.

module tb_shift_exec_stage;
    logic        Clk = 1'b0;
    logic        Rst;
    logic        In_Valid;
    logic        In_Ready;
    logic [5:0]  Funct;
    logic [4:0]  Shamt;
    logic [31:0] Rs;
    logic [31:0] Rt;
    logic        Flush;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Result;
    logic        Out_Err;

    int n_vec = 0;
    int n_bad = 0;
    logic [32:0] exp_q[$];

    shift_exec_stage dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Funct     (Funct),
        .Shamt     (Shamt),
        .Rs        (Rs),
        .Rt        (Rt),
        .Flush     (Flush),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Result    (Result),
        .Out_Err   (Out_Err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // A handshake seen at the negedge completes at the following posedge.
    always @(negedge Clk) begin
        if (Rst === 1'b0 && Out_Valid === 1'b1 && Out_Ready === 1'b1) begin
            logic [32:0] e;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: got res=0x%08h err=%0b, expected none", Result, Out_Err);
            end else begin
                e = exp_q.pop_front();
                if (Result !== e[31:0] || Out_Err !== e[32]) begin
                    n_bad++;
                    $display("FAIL scoreboard: got res=0x%08h err=%0b, expected res=0x%08h err=%0b",
                             Result, Out_Err, e[31:0], e[32]);
                end
            end
        end
    end

    // Presents one instruction and holds it until accepted (bounded).
    task automatic issue(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] er, input logic ee);
        bit done = 0;
        In_Valid = 1'b1;
        Funct    = f;
        Shamt    = sh;
        Rs       = rs;
        Rt       = rt;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge Clk);
            if (In_Ready === 1'b1) begin
                exp_q.push_back({ee, er});
                done = 1;
            end
            @(posedge Clk);
            #1;
        end
        In_Valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL issue_timeout: got In_Ready=0 for 50 cycles, expected accept");
        end
    endtask

    task automatic wait_drain;
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge Clk);
            #1;
            if (exp_q.size() == 0 && Out_Valid === 1'b0) done = 1;
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1; In_Valid = 1'b0; Funct = '0; Shamt = '0; Rs = '0; Rt = '0;
        Flush = 1'b0; Out_Ready = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
        check("rst_result", Result, 32'd0);
        check("rst_out_err", {31'd0, Out_Err}, 32'd0);
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        #1 check("rst_in_ready", {31'd0, In_Ready}, 32'd1);

        // sll with latency check: accept edge N, Out_Valid after N+1
        @(posedge Clk); #1;
        issue(6'b000000, 5'd4, 32'd0, 32'h0000000F, 32'h000000F0, 1'b0);
        check("lat_not_yet", {31'd0, Out_Valid}, 32'd0);
        @(posedge Clk); #1;
        check("lat_valid", {31'd0, Out_Valid}, 32'd1);
        wait_drain();

        // back-to-back directed shifts
        issue(6'b000011, 5'd31, 32'd0, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        issue(6'b000010, 5'd31, 32'd0, 32'h80000000, 32'h00000001, 1'b0);
        issue(6'b000011, 5'd0,  32'd0, 32'h12345678, 32'h12345678, 1'b0);
        issue(6'b000111, 5'd9,  32'h00000023, 32'hF0000000, 32'hFE000000, 1'b0);
        issue(6'b000100, 5'd7,  32'h00000020, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        issue(6'b000110, 5'd0,  32'hFFFFFFE4, 32'h80000000, 32'h08000000, 1'b0);
        issue(6'b000100, 5'd0,  32'h00000005, 32'h00000001, 32'h00000020, 1'b0);
        wait_drain();

        // backpressure: three sll by 1 with Out_Ready low for 4 cycles
        Out_Ready = 1'b0;
        fork
            begin
                issue(6'b000000, 5'd1, 32'd0, 32'd1, 32'd2, 1'b0);
                issue(6'b000000, 5'd1, 32'd0, 32'd2, 32'd4, 1'b0);
                issue(6'b000000, 5'd1, 32'd0, 32'd3, 32'd6, 1'b0);
            end
            begin
                repeat (4) @(posedge Clk);
                #1;
                check("bp_in_ready", {31'd0, In_Ready}, 32'd0);
                check("bp_result_hold", Result, 32'd2);
                check("bp_out_valid", {31'd0, Out_Valid}, 32'd1);
                check("bp_pending", exp_q.size(), 32'd2);
                Out_Ready = 1'b1;
            end
        join
        wait_drain();

        // flush with both stages full and a same-cycle In_Valid
        Out_Ready = 1'b0;
        issue(6'b000000, 5'd1, 32'd0, 32'd5, 32'd10, 1'b0);
        issue(6'b000000, 5'd1, 32'd0, 32'd6, 32'd12, 1'b0);
        check("fl_in_ready_full", {31'd0, In_Ready}, 32'd0);
        Flush = 1'b1; In_Valid = 1'b1; Funct = 6'b000000; Shamt = 5'd2; Rt = 32'd7;
        @(posedge Clk); #1;
        Flush = 1'b0; In_Valid = 1'b0;
        check("fl_out_valid", {31'd0, Out_Valid}, 32'd0);
        check("fl_in_ready", {31'd0, In_Ready}, 32'd1);
        exp_q.delete();
        Out_Ready = 1'b1;
        repeat (3) @(posedge Clk);
        #1 check("fl_nothing", {31'd0, Out_Valid}, 32'd0);
        issue(6'b000010, 5'd8, 32'd0, 32'h0000FF00, 32'h000000FF, 1'b0);
        wait_drain();

        // illegal funct
        issue(6'b100000, 5'd3, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b1);
        wait_drain();

        // async reset while holding a valid result
        Out_Ready = 1'b0;
        issue(6'b000000, 5'd8, 32'd0, 32'h00000011, 32'h00001100, 1'b0);
        @(posedge Clk); #1;
        check("ar_before", {31'd0, Out_Valid}, 32'd1);
        #2 Rst = 1'b1;
        #1;
        check("ar_out_valid", {31'd0, Out_Valid}, 32'd0);
        check("ar_result", Result, 32'd0);
        check("ar_out_err", {31'd0, Out_Err}, 32'd0);
        exp_q.delete();
        @(posedge Clk); #1;
        Rst = 1'b0; Out_Ready = 1'b1;
        #1 check("ar_in_ready", {31'd0, In_Ready}, 32'd1);
        issue(6'b000011, 5'd4, 32'd0, 32'h80000000, 32'hF8000000, 1'b0);
        wait_drain();

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
